cu_sequencer: RTL and testbench

//  Fetch/decode/execute controller for computational_unit: reads 8-bit instructions from program memory.

---
 rtl/cu_seq_pkg.sv | 74 +++++++
 rtl/cu_sequencer_decode.sv | 68 ++++++
 rtl/cu_sequencer.sv | 138 +++++++++++++
 tb/tb_cu_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cu_seq_pkg.sv
// Shared constants for the computational-unit sequencer: FSM state codes,
// opcode masks/values, data-bus source codes and register-enable bit indices.
package cu_seq_pkg;

    // FSM state codes
    localparam logic [2:0] ST_RST       = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_EXEC      = 3'd2;
    localparam logic [2:0] ST_FETCH_TGT = 3'd3;
    localparam logic [2:0] ST_HALT      = 3'd4;

    // Opcode classes: (ir & MASK) == VAL selects the class
    localparam logic [7:0] OP_LOAD_MASK = 8'h80;
    localparam logic [7:0] OP_LOAD_VAL  = 8'h00;
    localparam logic [7:0] OP_MOVE_MASK = 8'hC0;
    localparam logic [7:0] OP_MOVE_VAL  = 8'h80;
    localparam logic [7:0] OP_ALU_MASK  = 8'hE0;
    localparam logic [7:0] OP_ALU_VAL   = 8'hC0;

    // Full-byte control opcodes
    localparam logic [7:0] OP_JMP  = 8'hE0;
    localparam logic [7:0] OP_JNZ  = 8'hE1;
    localparam logic [7:0] OP_JZ   = 8'hE2;
    localparam logic [7:0] OP_HALT = 8'hFF;

    // Jump condition codes carried from decode to the take logic
    localparam logic [1:0] JC_ALWAYS = 2'd0;
    localparam logic [1:0] JC_NZ     = 2'd1;
    localparam logic [1:0] JC_Z      = 2'd2;

    // CU data_bus source codes
    localparam logic [3:0] SRC_X0 = 4'd0;
    localparam logic [3:0] SRC_X1 = 4'd1;
    localparam logic [3:0] SRC_Y0 = 4'd2;
    localparam logic [3:0] SRC_Y1 = 4'd3;
    localparam logic [3:0] SRC_R  = 4'd4;
    localparam logic [3:0] SRC_M  = 4'd5;
    localparam logic [3:0] SRC_I  = 4'd6;
    localparam logic [3:0] SRC_DM = 4'd7;
    localparam logic [3:0] SRC_PM = 4'd8;

    // Destination field codes that need special handling
    localparam logic [2:0] DEST_I  = 3'd6;
    localparam logic [2:0] DEST_DM = 3'd7;

    // reg_en bit indices
    localparam int REG_X0 = 0;
    localparam int REG_X1 = 1;
    localparam int REG_Y0 = 2;
    localparam int REG_Y1 = 3;
    localparam int REG_R  = 4;
    localparam int REG_M  = 5;
    localparam int REG_I  = 6;
    localparam int REG_DM = 7;
    localparam int REG_O  = 8;

    // Map a 3-bit destination field onto its one-hot register enable
    function automatic logic [8:0] dest_enable(input logic [2:0] dest);
        logic [8:0] en;
        en = '0;
        case (dest)
            3'd0:    en[REG_X0] = 1'b1;
            3'd1:    en[REG_X1] = 1'b1;
            3'd2:    en[REG_Y0] = 1'b1;
            3'd3:    en[REG_Y1] = 1'b1;
            3'd4:    en[REG_O]  = 1'b1;
            3'd5:    en[REG_M]  = 1'b1;
            3'd6:    en[REG_I]  = 1'b1;
            default: en[REG_DM] = 1'b1;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/cu_sequencer_decode.sv
// Purely combinational instruction decoder. Produces the raw CU control set
// for the instruction in ir; the sequencer gates these with the EXEC state.
module cu_instr_decode
    import cu_seq_pkg::*;
(
    input  logic [7:0] ir,
    output logic [3:0] source_sel,
    output logic [8:0] reg_en,
    output logic       i_sel,
    output logic       x_sel,
    output logic       y_sel,
    output logic       nibble_en,
    output logic       is_jump,
    output logic [1:0] jcond,
    output logic       is_halt
);

    logic [2:0] move_dest;
    logic [2:0] move_src;

    assign move_dest = ir[5:3];
    assign move_src  = ir[2:0];

    // Classify the opcode and build its control word; unlisted 111x codes stay all-zero NOPs
    always_comb begin
        source_sel = SRC_X0;
        reg_en     = '0;
        i_sel      = 1'b0;
        x_sel      = 1'b0;
        y_sel      = 1'b0;
        nibble_en  = 1'b0;
        is_jump    = 1'b0;
        jcond      = JC_ALWAYS;
        is_halt    = 1'b0;

        if ((ir & OP_LOAD_MASK) == OP_LOAD_VAL) begin
            source_sel = SRC_PM;
            reg_en     = dest_enable(ir[6:4]);
            nibble_en  = 1'b1;
        end else if ((ir & OP_MOVE_MASK) == OP_MOVE_VAL) begin
            source_sel = {1'b0, move_src};
            reg_en     = dest_enable(move_dest);
            // A dm access post-increments i, unless i itself is the destination
            if (move_dest != DEST_I &&
                ({1'b0, move_src} == SRC_DM || move_dest == DEST_DM)) begin
                reg_en[REG_I] = 1'b1;
                i_sel         = 1'b1;
            end
        end else if ((ir & OP_ALU_MASK) == OP_ALU_VAL) begin
            x_sel         = ir[4];
            y_sel         = ir[3];
            reg_en[REG_R] = 1'b1;
            nibble_en     = 1'b1;
        end else if (ir == OP_JMP) begin
            is_jump = 1'b1;
            jcond   = JC_ALWAYS;
        end else if (ir == OP_JNZ) begin
            is_jump = 1'b1;
            jcond   = JC_NZ;
        end else if (ir == OP_JZ) begin
            is_jump = 1'b1;
            jcond   = JC_Z;
        end else if (ir == OP_HALT) begin
            is_halt = 1'b1;
        end
    end

endmodule

// File: rtl/cu_sequencer.sv
// Fetch/decode/execute sequencer for the computational unit. Owns pc, ir,
// the latched jump decision and the FSM; CU controls are live only in EXEC.
module cu_sequencer
    import cu_seq_pkg::*;
#(
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [7:0]      pm_data,
    input  logic            pm_valid,
    input  logic            r_eq_0,
    output logic            pm_req,
    output logic [PC_W-1:0] pm_addr,
    output logic            sync_reset,
    output logic [3:0]      source_sel,
    output logic [8:0]      reg_en,
    output logic            i_sel,
    output logic            x_sel,
    output logic            y_sel,
    output logic [3:0]      ir_nibble,
    output logic            halted
);

    logic [2:0]      state;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic            take;
    logic            jump_take;
    logic            in_exec;

    logic [3:0]      dec_source_sel;
    logic [8:0]      dec_reg_en;
    logic            dec_i_sel;
    logic            dec_x_sel;
    logic            dec_y_sel;
    logic            dec_nibble_en;
    logic            dec_is_jump;
    logic [1:0]      dec_jcond;
    logic            dec_is_halt;

    // Zero-extend or truncate an 8-bit jump target to the pc width
    function automatic logic [PC_W-1:0] target_of(input logic [7:0] data);
        logic [PC_W-1:0] t;
        t = '0;
        for (int k = 0; k < PC_W && k < 8; k++) begin
            t[k] = data[k];
        end
        return t;
    endfunction

    cu_instr_decode u_decode (
        .ir         (ir),
        .source_sel (dec_source_sel),
        .reg_en     (dec_reg_en),
        .i_sel      (dec_i_sel),
        .x_sel      (dec_x_sel),
        .y_sel      (dec_y_sel),
        .nibble_en  (dec_nibble_en),
        .is_jump    (dec_is_jump),
        .jcond      (dec_jcond),
        .is_halt    (dec_is_halt)
    );

    // Evaluate the branch condition against the CU zero flag seen during EXEC
    always_comb begin
        jump_take = 1'b0;
        case (dec_jcond)
            JC_ALWAYS: jump_take = 1'b1;
            JC_NZ:     jump_take = ~r_eq_0;
            JC_Z:      jump_take = r_eq_0;
            default:   jump_take = 1'b0;
        endcase
    end

    // Sequencer FSM plus pc/ir/take registers; reset aborts any fetch in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RST;
            pc    <= PC_W'(RESET_PC);
            ir    <= 8'h00;
            take  <= 1'b0;
        end else begin
            case (state)
                ST_RST: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (pm_valid) begin
                        ir    <= pm_data;
                        pc    <= pc + PC_W'(1);
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (dec_is_halt) begin
                        state <= ST_HALT;
                    end else if (dec_is_jump) begin
                        take  <= jump_take;
                        state <= ST_FETCH_TGT;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH_TGT: begin
                    if (pm_valid) begin
                        pc    <= take ? target_of(pm_data) : pc + PC_W'(1);
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_RST;
                end
            endcase
        end
    end

    assign in_exec = (state == ST_EXEC);

    // Drive outputs from state; decoded controls only escape during EXEC
    always_comb begin
        pm_req     = (state == ST_FETCH) || (state == ST_FETCH_TGT);
        pm_addr    = pc;
        sync_reset = (state == ST_RST);
        halted     = (state == ST_HALT);
        source_sel = in_exec ? dec_source_sel : 4'd0;
        reg_en     = in_exec ? dec_reg_en : 9'd0;
        i_sel      = in_exec & dec_i_sel;
        x_sel      = in_exec & dec_x_sel;
        y_sel      = in_exec & dec_y_sel;
        ir_nibble  = (in_exec && dec_nibble_en) ? ir[3:0] : 4'd0;
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: acts as program memory with random
// wait states and compares every cycle against an instruction-level model.
module tb_cu_sequencer;

    logic       clk;
    logic       reset_n;
    logic [7:0] pm_data;
    logic       pm_valid;
    logic       r_eq_0;
    logic       pm_req;
    logic [7:0] pm_addr;
    logic       sync_reset;
    logic [3:0] source_sel;
    logic [8:0] reg_en;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;
    logic [3:0] ir_nibble;
    logic       halted;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [256];
    logic [7:0] mpc;
    int dest_bit [8] = '{0, 1, 2, 3, 8, 5, 6, 7};

    cu_sequencer #(.PC_W(8), .RESET_PC(0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pm_data    (pm_data),
        .pm_valid   (pm_valid),
        .r_eq_0     (r_eq_0),
        .pm_req     (pm_req),
        .pm_addr    (pm_addr),
        .sync_reset (sync_reset),
        .source_sel (source_sel),
        .reg_en     (reg_en),
        .i_sel      (i_sel),
        .x_sel      (x_sel),
        .y_sel      (y_sel),
        .ir_nibble  (ir_nibble),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_word();
        return 32'({source_sel, reg_en, i_sel, x_sel, y_sel, ir_nibble});
    endfunction

    // Instruction-level meaning of one opcode, straight from the decode table
    task automatic model_decode(input logic [7:0] ins, output logic [3:0] src,
                                output logic [8:0] en, output logic isel,
                                output logic xs, output logic ys, output logic [3:0] nib);
        int op;
        int d;
        int s;
        op = int'(ins);
        src = 0; en = 0; isel = 0; xs = 0; ys = 0; nib = 0;
        if (op < 128) begin
            src = 4'd8;
            en  = 9'(1 << dest_bit[(op / 16) % 8]);
            nib = 4'(op % 16);
        end else if (op < 192) begin
            d   = (op / 8) % 8;
            s   = op % 8;
            src = 4'(s);
            en  = 9'(1 << dest_bit[d]);
            if (d != 6 && (s == 7 || d == 7)) begin
                en   = en | 9'h040;
                isel = 1'b1;
            end
        end else if (op < 224) begin
            xs  = 1'((op / 16) % 2);
            ys  = 1'((op / 8) % 2);
            nib = 4'(op % 16);
            en  = 9'h010;
        end
    endtask

    // Serve one program-memory read at mpc after the given number of wait cycles
    task automatic serve_fetch(input int waits, input string tag);
        for (int w = 0; w < waits; w++) begin
            pm_valid = 1'b0;
            pm_data  = 8'($urandom);
            check({tag, "_wait_req"}, 32'(pm_req), 32'd1);
            check({tag, "_wait_addr"}, 32'(pm_addr), 32'(mpc));
            check({tag, "_wait_ctrl"}, ctrl_word(), 32'd0);
            @(negedge clk);
        end
        check({tag, "_req"}, 32'(pm_req), 32'd1);
        check({tag, "_addr"}, 32'(pm_addr), 32'(mpc));
        check({tag, "_sync"}, 32'(sync_reset), 32'd0);
        pm_valid = 1'b1;
        pm_data  = mem[mpc];
        @(negedge clk);
    endtask

    // Fetch, execute and (for jumps) resolve one instruction, checking each cycle
    task automatic do_instr(input int waits, input logic r);
        logic [7:0] ins;
        logic [3:0] e_src;
        logic [8:0] e_en;
        logic       e_isel, e_xs, e_ys;
        logic [3:0] e_nib;
        logic       tk;
        serve_fetch(waits, "fetch");
        ins = mem[mpc];
        mpc = mpc + 8'd1;
        pm_valid = 1'($urandom);
        pm_data  = 8'($urandom);
        r_eq_0   = r;
        model_decode(ins, e_src, e_en, e_isel, e_xs, e_ys, e_nib);
        check("exec_source_sel", 32'(source_sel), 32'(e_src));
        check("exec_reg_en", 32'(reg_en), 32'(e_en));
        check("exec_i_sel", 32'(i_sel), 32'(e_isel));
        check("exec_x_sel", 32'(x_sel), 32'(e_xs));
        check("exec_y_sel", 32'(y_sel), 32'(e_ys));
        check("exec_ir_nibble", 32'(ir_nibble), 32'(e_nib));
        check("exec_pm_req", 32'(pm_req), 32'd0);
        @(negedge clk);
        r_eq_0 = 1'($urandom);
        tk = (ins == 8'hE0) || (ins == 8'hE1 && !r) || (ins == 8'hE2 && r);
        if (ins == 8'hFF) begin
            for (int h = 0; h < 6; h++) begin
                pm_valid = 1'($urandom);
                pm_data  = 8'($urandom);
                check("halt_halted", 32'(halted), 32'd1);
                check("halt_pm_req", 32'(pm_req), 32'd0);
                check("halt_ctrl", ctrl_word(), 32'd0);
                @(negedge clk);
            end
        end else if (ins >= 8'hE0 && ins <= 8'hE2) begin
            serve_fetch(waits, "tgt");
            mpc = tk ? mem[mpc] : mpc + 8'd1;
        end
    endtask

    // Pulse reset from the current negedge and check the reset-release sequence
    task automatic do_reset();
        reset_n  = 1'b0;
        pm_valid = 1'b0;
        #1;
        check("rst_sync_reset", 32'(sync_reset), 32'd1);
        check("rst_pm_req", 32'(pm_req), 32'd0);
        check("rst_pm_addr", 32'(pm_addr), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_ctrl", ctrl_word(), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_sync_reset", 32'(sync_reset), 32'd1);
        @(negedge clk);
        check("post_sync_reset", 32'(sync_reset), 32'd0);
        mpc = 8'd0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        pm_valid = 1'b0;
        pm_data  = 8'h00;
        r_eq_0   = 1'b0;
        mpc      = 8'd0;
        for (int a = 0; a < 256; a++) mem[a] = 8'hE5;

        mem[8'h00] = 8'h05; mem[8'h01] = 8'h88;
        mem[8'h02] = 8'hC1; mem[8'h03] = 8'hE1; mem[8'h04] = 8'h10;
        mem[8'h05] = 8'hE1; mem[8'h06] = 8'h20;
        mem[8'h20] = 8'h87; mem[8'h21] = 8'hB0;

        @(negedge clk);
        do_reset();

        do_instr(0, 1'b0);
        do_instr(0, 1'b1);
        do_instr(0, 1'b0);
        do_instr(0, 1'b1);
        check("jnz_not_taken_pc", 32'(pm_addr), 32'h05);
        do_instr(3, 1'b0);
        check("jnz_taken_pc", 32'(pm_addr), 32'h20);
        do_instr(1, 1'b0);
        do_instr(2, 1'b1);

        pm_valid = 1'b0;
        @(negedge clk);
        check("midfetch_addr", 32'(pm_addr), 32'h22);
        @(negedge clk);
        do_reset();

        for (int a = 0; a < 256; a++) begin
            mem[a] = 8'($urandom);
            if (mem[a] == 8'hFF) mem[a] = 8'hE5;
        end
        for (int n = 0; n < 150; n++) begin
            do_instr($urandom_range(0, 3), 1'($urandom));
        end

        @(negedge clk);
        do_reset();
        mem[8'h00] = 8'hE0; mem[8'h01] = 8'hFF;
        mem[8'hFF] = 8'hE0; mem[8'hE0] = 8'hFF;
        do_instr(0, 1'b0);
        check("jmp_to_ff", 32'(pm_addr), 32'hFF);
        do_instr(1, 1'b1);
        check("wrap_then_jmp", 32'(pm_addr), 32'hE0);
        do_instr(0, 1'b0);
        check("halted_sticky", 32'(halted), 32'd1);

        do_reset();
        check("halt_cleared", 32'(halted), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
